// File: rtl/result_collector_multi_pkg.sv
// Shared helpers for the multi-channel result collector: sizing functions and
// the FIFO entry layout, which is {channel, sum, count} from MSB to LSB.
package collector_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // A single-channel build still carries a 1-bit channel tag.
  function automatic int tag_width(input int num_channels);
    return (num_channels > 1) ? clog2(num_channels) : 1;
  endfunction

  function automatic int entry_width(input int tag_w, input int sum_w, input int count_w);
    return tag_w + sum_w + count_w;
  endfunction

endpackage

// File: rtl/result_collector_multi_if.sv
// Bundle of pipeline-side and readout-side signals of the result collector.
// The master view belongs to the collector, the slave view to its environment.
interface result_collector_multi_if
  import collector_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SUM_WIDTH    = 48,
  parameter int COUNT_WIDTH  = 13,
  parameter int DEPTH_LOG2   = 5
);
  localparam int TAG_W = tag_width(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0]             chanAvailable;
  logic [NUM_CHANNELS-1:0]             chanGrab;
  logic [NUM_CHANNELS*SUM_WIDTH-1:0]   chanSum;
  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] chanCount;
  logic                                grabResults;
  logic                                resultsAvailable;
  logic [SUM_WIDTH-1:0]                pcoeffSum;
  logic [COUNT_WIDTH-1:0]              pcoeffCount;
  logic [TAG_W-1:0]                    resultChannel;
  logic [DEPTH_LOG2:0]                 grabsOutstanding;

  modport master (
    input  chanAvailable, chanSum, chanCount, grabResults,
    output chanGrab, resultsAvailable, pcoeffSum, pcoeffCount, resultChannel, grabsOutstanding
  );

  modport slave (
    output chanAvailable, chanSum, chanCount, grabResults,
    input  chanGrab, resultsAvailable, pcoeffSum, pcoeffCount, resultChannel, grabsOutstanding
  );
endinterface

// File: rtl/result_collector_multi_fifo.sv
// Show-ahead FIFO: the head entry is visible on rd_data while not empty and
// reads as zero when empty; rd_en pops it.
module collector_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   usedw
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   usedw_q, usedw_d;
  logic                  do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && (usedw_q != (DEPTH_LOG2+1)'(DEPTH));
    do_rd    = rd_en && (usedw_q != '0);
    wr_ptr_d = do_wr ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    usedw_d  = usedw_q;
    if (do_wr && !do_rd) begin
      usedw_d = usedw_q + (DEPTH_LOG2+1)'(1);
    end else if (!do_wr && do_rd) begin
      usedw_d = usedw_q - (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
    end
  end

  // Storage is left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign empty   = (usedw_q == '0);
  assign usedw   = usedw_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/result_collector_multi.sv
// Round-robin, interval-paced result grabber over NUM_CHANNELS pipelines; a
// credit counter reserves FIFO space at grab time so late data never overflows.
module result_collector_multi
  import collector_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int SUM_WIDTH     = 48,
  parameter int COUNT_WIDTH   = 13,
  parameter int DEPTH_LOG2    = 5,
  parameter int GRAB_INTERVAL = 8,
  parameter int DATA_LATENCY  = 8
) (
  input logic                      clk,
  input logic                      rst,
  result_collector_multi_if.master bus
);
  localparam int TAG_W   = tag_width(NUM_CHANNELS);
  localparam int RETRY_W = clog2(GRAB_INTERVAL);
  localparam int CRED_W  = DEPTH_LOG2 + 1;
  localparam int ENTRY_W = entry_width(TAG_W, SUM_WIDTH, COUNT_WIDTH);
  localparam logic [CRED_W-1:0]  CRED_MAX   = CRED_W'(1 << DEPTH_LOG2);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(GRAB_INTERVAL - 1);
  localparam logic [TAG_W-1:0]   CHAN_LAST  = TAG_W'(NUM_CHANNELS - 1);

  logic [CRED_W-1:0]       credits_q, credits_d;
  logic [RETRY_W-1:0]      retry_cnt_q, retry_cnt_d;
  logic [TAG_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    tag_vld_q [DATA_LATENCY];
  logic                    tag_vld_d [DATA_LATENCY];
  logic [TAG_W-1:0]        tag_chan_q [DATA_LATENCY];
  logic [TAG_W-1:0]        tag_chan_d [DATA_LATENCY];
  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] grab_vec;
  logic [TAG_W-1:0]        grant;
  logic                    found;
  logic                    issue;
  logic                    fifo_pop;
  logic                    fifo_empty;
  logic [CRED_W-1:0]       fifo_usedw;
  logic [TAG_W-1:0]        wr_chan;
  logic [ENTRY_W-1:0]      fifo_wdata, fifo_rdata;

  // The cooldown masks a channel whose available flag is still stale after a grab.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    logic [RETRY_W-1:0] cooldown_q, cooldown_d;

    always_comb begin
      cooldown_d = cooldown_q;
      if (grab_vec[gi]) begin
        cooldown_d = RETRY_LAST;
      end else if (cooldown_q != '0) begin
        cooldown_d = cooldown_q - RETRY_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cooldown_q <= '0;
      end else begin
        cooldown_q <= cooldown_d;
      end
    end

    assign eligible[gi] = bus.chanAvailable[gi] && (cooldown_q == '0);
  end

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CHANNELS) begin
        idx = idx - NUM_CHANNELS;
      end
      if (!found && eligible[idx]) begin
        found = 1'b1;
        grant = TAG_W'(idx);
      end
    end
    // Gating by rst keeps chanGrab low while the block is held in reset.
    issue    = rst && found && (retry_cnt_q == '0) && (credits_q != '0);
    grab_vec = issue ? (NUM_CHANNELS'(1) << grant) : '0;
  end

  always_comb begin
    retry_cnt_d = (retry_cnt_q == RETRY_LAST) ? '0 : retry_cnt_q + RETRY_W'(1);
    rr_ptr_d    = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (grant == CHAN_LAST) ? '0 : grant + TAG_W'(1);
    end
    credits_d = credits_q;
    if (issue && !fifo_pop) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!issue && fifo_pop) begin
      credits_d = credits_q + CRED_W'(1);
    end
    tag_vld_d[0]  = issue;
    tag_chan_d[0] = grant;
    for (int i = 1; i < DATA_LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_chan_d[i] = tag_chan_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q   <= CRED_MAX;
      retry_cnt_q <= '0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < DATA_LATENCY; i++) begin
        tag_vld_q[i]  <= 1'b0;
        tag_chan_q[i] <= '0;
      end
    end else begin
      credits_q   <= credits_d;
      retry_cnt_q <= retry_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int i = 0; i < DATA_LATENCY; i++) begin
        tag_vld_q[i]  <= tag_vld_d[i];
        tag_chan_q[i] <= tag_chan_d[i];
      end
    end
  end

  // The emerging tag selects which channel bus is captured this cycle.
  assign wr_chan    = tag_chan_q[DATA_LATENCY-1];
  assign fifo_wdata = {wr_chan,
                       bus.chanSum[int'(wr_chan)*SUM_WIDTH +: SUM_WIDTH],
                       bus.chanCount[int'(wr_chan)*COUNT_WIDTH +: COUNT_WIDTH]};
  assign fifo_pop   = bus.grabResults && !fifo_empty;

  collector_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tag_vld_q[DATA_LATENCY-1]),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .usedw   (fifo_usedw)
  );

  assign bus.chanGrab         = grab_vec;
  assign bus.resultsAvailable = (fifo_usedw != '0);
  assign {bus.resultChannel, bus.pcoeffSum, bus.pcoeffCount} = fifo_rdata;
  assign bus.grabsOutstanding = CRED_MAX - credits_q;
endmodule
